// File: rtl/nonce_register.sv
// Nonce payload collector: shifts the bytes following a nonce command into
// a shadow register and publishes the complete word in a single update.
module nonce_register #(
  parameter int NONCE_BYTES = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     nonce_i,
  input  logic                     new_data_i,
  input  logic [7:0]               data_i,
  input  logic                     timed_out_i,
  output logic                     timeout_counter_reset_o,
  output logic                     nonce_register_ready_o,
  output logic                     nonce_aborted_o,
  output logic                     new_nonce_o,
  output logic                     nonce_valid_o,
  output logic [8*NONCE_BYTES-1:0] nonce_o
);

  localparam int W  = 8 * NONCE_BYTES;
  localparam int CW = $clog2(NONCE_BYTES);
  localparam logic [CW-1:0] LAST = CW'(NONCE_BYTES - 1);

  typedef enum logic {
    IDLE,
    LOAD
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [W-1:0]  r_shadow;
  logic [W-1:0]  w_shadow_nxt;
  logic [W-1:0]  r_nonce;
  logic [W-1:0]  w_nonce_nxt;
  logic [W-1:0]  w_shift;
  logic          r_valid;
  logic          w_valid_nxt;
  logic          r_ready;
  logic          w_ready_nxt;
  logic          r_abort;
  logic          w_abort_nxt;
  logic          r_new;
  logic          w_new_nxt;
  logic          w_tcr;

  assign w_shift = {r_shadow[W-9:0], data_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_nonce  <= '0;
      r_valid  <= 1'b0;
      r_ready  <= 1'b0;
      r_abort  <= 1'b0;
      r_new    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shadow <= w_shadow_nxt;
      r_nonce  <= w_nonce_nxt;
      r_valid  <= w_valid_nxt;
      r_ready  <= w_ready_nxt;
      r_abort  <= w_abort_nxt;
      r_new    <= w_new_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shadow_nxt = r_shadow;
    w_nonce_nxt  = r_nonce;
    w_valid_nxt  = r_valid;
    w_ready_nxt  = 1'b0;
    w_abort_nxt  = 1'b0;
    w_new_nxt    = 1'b0;
    w_tcr        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (nonce_i) begin
          w_tcr       = 1'b1;
          w_state_nxt = LOAD;
          w_cnt_nxt   = '0;
        end
      end
      LOAD: begin
        // timeout outranks a byte arriving in the same cycle
        if (timed_out_i) begin
          w_state_nxt  = IDLE;
          w_cnt_nxt    = '0;
          w_shadow_nxt = '0;
          w_ready_nxt  = 1'b1;
          w_abort_nxt  = 1'b1;
        end else if (new_data_i) begin
          w_tcr = 1'b1;
          if (r_cnt == LAST) begin
            w_nonce_nxt = w_shift;
            w_valid_nxt = 1'b1;
            w_ready_nxt = 1'b1;
            w_new_nxt   = 1'b1;
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_shadow_nxt = w_shift;
            w_cnt_nxt    = r_cnt + CW'(1);
          end
        end
      end
    endcase
  end

  assign timeout_counter_reset_o = w_tcr;
  assign nonce_register_ready_o  = r_ready;
  assign nonce_aborted_o         = r_abort;
  assign new_nonce_o             = r_new;
  assign nonce_valid_o           = r_valid;
  assign nonce_o                 = r_nonce;

endmodule
